// File: rtl/ccff_bitstream_loader.sv
// Host-side loader for the ccff configuration chain: serializes bytes MSB-first
// onto ccff_head, gates the chain clock, and returns tail bits as readback bytes.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 2,
  parameter int CNT_W     = 16
) (
  input  logic             prog_clk,
  input  logic             prog_reset_n,
  input  logic             start,
  input  logic [7:0]       cfg_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             ccff_head,
  output logic             chain_clk_en,
  input  logic             ccff_tail,
  output logic [7:0]       rb_data,
  output logic             rb_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_count
);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);

  state_t           state_q, state_d;
  logic [7:0]       sreg_q, sreg_d;
  logic [7:0]       rbs_q, rbs_d;
  logic [7:0]       rb_data_q, rb_data_d;
  logic [2:0]       rem_q, rem_d;
  logic [2:0]       rbn_q, rbn_d;
  logic             rdy_q, rdy_d;
  logic             head_q, head_d;
  logic             en_q, en_d;
  logic             rbv_q, rbv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;

  logic [CNT_W-1:0] left;
  logic [3:0]       nbits;
  logic [7:0]       rb_next;
  logic [3:0]       rb_fill;
  logic             rb_last;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    rbs_d       = rbs_q;
    rb_data_d   = rb_data_q;
    rem_d       = rem_q;
    rbn_d       = rbn_q;
    rdy_d       = rdy_q;
    head_d      = head_q;
    en_d        = en_q;
    rbv_d       = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    bit_count_d = bit_count_q;

    left    = LEN - bit_count_q;
    nbits   = (left > CNT_W'(8)) ? 4'd8 : left[3:0];
    rb_next = {rbs_q[6:0], ccff_tail};
    rb_fill = {1'b0, rbn_q} + 4'd1;
    rb_last = (bit_count_q == LEN);

    // bit_count already includes the bit in flight, so rb_last marks the final tail sample
    if (en_q) begin
      rbs_d = rb_next;
      rbn_d = rbn_q + 3'd1;
      if (rb_fill == 4'd8 || rb_last) begin
        rb_data_d = rb_next << (4'd8 - rb_fill);
        rbv_d     = 1'b1;
        rbn_d     = 3'd0;
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = FETCH;
          rdy_d       = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          bit_count_d = '0;
          rbn_d       = 3'd0;
          rbs_d       = 8'd0;
        end
      end
      FETCH: begin
        if (cfg_valid && rdy_q) begin
          state_d     = SHIFT;
          rdy_d       = 1'b0;
          en_d        = 1'b1;
          head_d      = cfg_data[7];
          sreg_d      = {cfg_data[6:0], 1'b0};
          bit_count_d = bit_count_q + CNT_W'(1);
          rem_d       = 3'(nbits - 4'd1);
        end
      end
      SHIFT: begin
        if (rem_q != 3'd0) begin
          head_d      = sreg_q[7];
          sreg_d      = {sreg_q[6:0], 1'b0};
          bit_count_d = bit_count_q + CNT_W'(1);
          rem_d       = rem_q - 3'd1;
        end else begin
          en_d = 1'b0;
          if (bit_count_q == LEN) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
            rdy_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q     <= IDLE;
      sreg_q      <= 8'd0;
      rbs_q       <= 8'd0;
      rb_data_q   <= 8'd0;
      rem_q       <= 3'd0;
      rbn_q       <= 3'd0;
      rdy_q       <= 1'b0;
      head_q      <= 1'b0;
      en_q        <= 1'b0;
      rbv_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      rbs_q       <= rbs_d;
      rb_data_q   <= rb_data_d;
      rem_q       <= rem_d;
      rbn_q       <= rbn_d;
      rdy_q       <= rdy_d;
      head_q      <= head_d;
      en_q        <= en_d;
      rbv_q       <= rbv_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign cfg_ready    = rdy_q;
  assign ccff_head    = head_q;
  assign chain_clk_en = en_q;
  assign rb_data      = rb_data_q;
  assign rb_valid     = rbv_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign bit_count    = bit_count_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: four loaders of different chain lengths,
// each driving a behavioural shift chain, exercised with directed loads.
module tb_ccff_bitstream_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cfg_data = 8'd0;
  logic       cfg_valid = 1'b0;
  logic [3:0] st = 4'd0;
  logic [3:0] rdy, head, en, tail, rbv, busy, done;
  logic [7:0] rbd [4];
  logic [15:0] bc [4];
  logic [31:0] ch [4] = '{default: '0};

  int checks = 0;
  int errors = 0;
  int enn [4];
  int rbn [4];
  logic [7:0] rbm [4][8];
  int gapbad = 0;
  bit gap = 1'b0;
  int cur = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 19 : (g == 2) ? 16 : 8;
    ccff_bitstream_loader #(.CHAIN_LEN(L), .CNT_W(16)) u_dut (
      .prog_clk     (clk),
      .prog_reset_n (rst_n),
      .start        (st[g]),
      .cfg_data     (cfg_data),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (rdy[g]),
      .ccff_head    (head[g]),
      .chain_clk_en (en[g]),
      .ccff_tail    (tail[g]),
      .rb_data      (rbd[g]),
      .rb_valid     (rbv[g]),
      .busy         (busy[g]),
      .done         (done[g]),
      .bit_count    (bc[g])
    );
    assign tail[g] = ch[g][L-1];
  end

  always @(posedge clk)
    for (int k = 0; k < 4; k++)
      if (en[k]) ch[k] <= {ch[k][30:0], head[k]};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (en[k]) enn[k]++;
      if (rbv[k]) begin
        if (rbn[k] < 8) rbm[k][rbn[k]] = rbd[k];
        rbn[k]++;
      end
    end
    if (gap && en[cur]) gapbad++;
  endtask

  task automatic clr(input int k);
    enn[k] = 0;
    rbn[k] = 0;
    gapbad = 0;
    for (int i = 0; i < 8; i++) rbm[k][i] = 8'd0;
  endtask

  task automatic load(input int k, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input int n, input bit stall,
                      input bit poke);
    int t;
    clr(k);
    cur = k;
    st[k] = 1'b1;
    tick();
    st[k] = 1'b0;
    chk("rdy_lat", rdy[k], 1);
    for (int i = 0; i < n; i++) begin
      cfg_data = (i == 0) ? b0 : (i == 1) ? b1 : b2;
      cfg_valid = 1'b1;
      t = 0;
      while (!rdy[k] && t < 200) begin tick(); t++; end
      tick();
      if (i == 0) chk("en_lat", en[k], 1);
      if (poke && i == 0) begin
        st[k] = 1'b1;
        tick();
        st[k] = 1'b0;
      end
      if (stall) begin
        cfg_valid = 1'b0;
        t = 0;
        while (!rdy[k] && t < 200) begin tick(); t++; end
        gap = 1'b1;
        repeat (5) tick();
        gap = 1'b0;
      end
    end
    cfg_valid = 1'b0;
    t = 0;
    while (!done[k] && t < 200) begin tick(); t++; end
    chk($sformatf("done%0d", k), done[k], 1);
    chk($sformatf("busy%0d", k), busy[k], 0);
  endtask

  initial begin
    int t;
    for (int k = 0; k < 4; k++) clr(k);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rst_rdy", rdy[k], 0);
      chk("rst_en", en[k], 0);
      chk("rst_bc", bc[k], 0);
      chk("rst_done", done[k], 0);
    end
    chk("rst_busy", busy[0], 0);
    chk("rst_rbd", rbd[0], 0);
    rst_n = 1'b1;
    tick();

    load(0, 8'h80, 8'h00, 8'h00, 1, 1'b0, 1'b0);
    chk("l2_chain", ch[0][1:0], 2'b10);
    chk("l2_bc", bc[0], 2);
    chk("l2_en", enn[0], 2);
    chk("l2_rbn", rbn[0], 1);
    load(0, 8'h40, 8'h00, 8'h00, 1, 1'b0, 1'b0);
    chk("l2_rb", rbm[0][0], 8'h80);
    chk("l2_chain2", ch[0][1:0], 2'b01);
    chk("l2_en2", enn[0], 2);

    load(1, 8'hA5, 8'h3C, 8'hE0, 3, 1'b0, 1'b0);
    chk("l19_chain", ch[1][18:0], 19'h529E7);
    chk("l19_en", enn[1], 19);
    chk("l19_rbn", rbn[1], 3);
    chk("l19_bc", bc[1], 19);
    load(1, 8'h00, 8'h00, 8'h00, 3, 1'b0, 1'b0);
    chk("l19_rb0", rbm[1][0], 8'hA5);
    chk("l19_rb1", rbm[1][1], 8'h3C);
    chk("l19_rb2", rbm[1][2], 8'hE0);
    chk("l19_zero", ch[1][18:0], 0);

    load(2, 8'h5A, 8'hC3, 8'h00, 2, 1'b1, 1'b0);
    chk("stall_chain", ch[2][15:0], 16'h5AC3);
    chk("stall_gap", gapbad, 0);
    chk("stall_en", enn[2], 16);

    load(3, 8'hFF, 8'h00, 8'h00, 1, 1'b0, 1'b0);
    load(3, 8'h00, 8'h00, 8'h00, 1, 1'b0, 1'b1);
    chk("l8_rb", rbm[3][0], 8'hFF);
    chk("l8_chain", ch[3][7:0], 8'h00);
    chk("l8_en", enn[3], 8);
    chk("l8_bc", bc[3], 8);
    chk("l8_rbn", rbn[3], 1);

    cur = 2;
    clr(2);
    st[2] = 1'b1;
    tick();
    st[2] = 1'b0;
    cfg_data = 8'hFF;
    cfg_valid = 1'b1;
    t = 0;
    while (bc[2] != 16'd5 && t < 100) begin tick(); t++; end
    chk("mid_bc", bc[2], 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bc", bc[2], 0);
    chk("arst_busy", busy[2], 0);
    chk("arst_en", en[2], 0);
    chk("arst_head", head[2], 0);
    chk("arst_rdy", rdy[2], 0);
    cfg_valid = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    load(2, 8'h12, 8'h34, 8'h00, 2, 1'b0, 1'b0);
    chk("rl_chain", ch[2][15:0], 16'h1234);
    chk("rl_bc", bc[2], 16);
    chk("rl_en", enn[2], 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
